// File: rtl/mdio_clause22_phy.sv
// MDIO Clause 22 responder: oversamples MDC on clk, decodes master frames,
// drives read data back on mdio and issues single-cycle register-file strobes.
module mdio_clause22_phy #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_wr,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_err
);
  localparam int            PW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

  typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

  logic [SYNC_STAGES-1:0] mdc_s, mdio_s;
  logic                   mdc_prev;
  logic                   mdc_rise, sdi;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdc_s    <= '0;
      mdio_s   <= '0;
      mdc_prev <= 1'b0;
    end else begin
      mdc_s    <= {mdc_s[SYNC_STAGES-2:0], mdc};
      mdio_s   <= {mdio_s[SYNC_STAGES-2:0], mdio_i};
      mdc_prev <= mdc_s[SYNC_STAGES-1];
    end
  end

  assign mdc_rise = mdc_s[SYNC_STAGES-1] & ~mdc_prev;
  assign sdi      = mdio_s[SYNC_STAGES-1];

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic          op0, is_rd, rd_cap;
  logic [15:0]   sh, tx;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= HUNT;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      op0         <= 1'b0;
      is_rd       <= 1'b0;
      rd_cap      <= 1'b0;
      sh          <= '0;
      tx          <= '0;
      mdio_o      <= 1'b0;
      mdio_oe     <= 1'b0;
      reg_addr    <= '0;
      reg_wr      <= 1'b0;
      reg_wr_data <= '0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      // read data arrives the clk after reg_rd; MDC is far slower, so it lands before TA
      rd_cap    <= reg_rd;
      if (rd_cap) tx <= reg_rd_data;
      if (mdc_rise) begin
        unique case (state)
          HUNT: begin
            if (sdi) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
            end else if (pre_cnt == PRE_MAX) begin
              state   <= ST;
              busy    <= 1'b1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          ST: begin
            if (sdi) begin
              state   <= OP;
              bit_cnt <= '0;
            end else begin
              state     <= HUNT;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
          OP: begin
            if (bit_cnt == 5'd0) begin
              op0     <= sdi;
              bit_cnt <= 5'd1;
            end else if (op0 != sdi) begin
              is_rd   <= op0;
              state   <= PHYAD;
              bit_cnt <= '0;
            end else begin
              state     <= HUNT;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
          PHYAD: begin
            sh <= {sh[14:0], sdi};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              if ({sh[3:0], sdi} == PHY_ADDR) state <= REGAD;
              else begin
                state <= HUNT;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          REGAD: begin
            sh <= {sh[14:0], sdi};
            if (bit_cnt == 5'd4) begin
              reg_addr <= {sh[3:0], sdi};
              reg_rd   <= is_rd;
              state    <= TA;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TA: begin
            // reads ignore mdio here: the master has released the line
            if (bit_cnt == 5'd0) begin
              if (!is_rd && !sdi) begin
                state     <= HUNT;
                busy      <= 1'b0;
                frame_err <= 1'b1;
              end else begin
                bit_cnt <= 5'd1;
              end
            end else if (is_rd) begin
              mdio_oe <= 1'b1;
              mdio_o  <= 1'b0;
              state   <= DATA;
              bit_cnt <= '0;
            end else if (sdi) begin
              state     <= HUNT;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (is_rd) begin
              if (bit_cnt == 5'd16) begin
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b0;
                busy    <= 1'b0;
                state   <= HUNT;
              end else begin
                mdio_o  <= tx[15];
                tx      <= {tx[14:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              sh <= {sh[14:0], sdi};
              if (bit_cnt == 5'd15) begin
                reg_wr      <= 1'b1;
                reg_wr_data <= {sh[14:0], sdi};
                busy        <= 1'b0;
                state       <= HUNT;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdio_clause22_phy.sv
// Bench: MDIO master driving frames, a register file behind the strobes, and a
// frame-level model predicting strobes, errors and returned read bits.
module tb_mdio_clause22_phy;
  localparam logic [4:0] PHY  = 5'd1;
  localparam int         PLEN = 32;

  logic        clk = 1'b0, arst_n = 1'b0, mdc = 1'b0, m_oe = 1'b0, m_d = 1'b1;
  logic        mdio_o, mdio_oe, reg_wr, reg_rd, busy, frame_err, mdio_line;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data, rd_q;

  mdio_clause22_phy #(.PHY_ADDR(PHY), .PREAMBLE_LEN(PLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .arst_n(arst_n), .mdc(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wr_data(reg_wr_data), .reg_rd(reg_rd), .reg_rd_data(rd_q),
    .busy(busy), .frame_err(frame_err)
  );

  // shared line with pull-up
  assign mdio_line = mdio_oe ? mdio_o : (m_oe ? m_d : 1'b1);

  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(input logic [4:0] a);
    return {a, 11'h2A5};
  endfunction

  // register file behind the strobe port
  logic [15:0] mem [32];
  logic [31:0] mem_vld;
  logic        tb_init = 1'b1;
  always @(posedge clk) begin
    if (tb_init) mem_vld <= '0;
    else if (reg_wr) begin
      mem[reg_addr]     <= reg_wr_data;
      mem_vld[reg_addr] <= 1'b1;
    end
    if (reg_rd) rd_q <= mem_vld[reg_addr] ? mem[reg_addr] : dflt(reg_addr);
  end

  int          n_wr, n_rd, n_err, n_oe, n_both;
  logic [4:0]  last_wa;
  logic [15:0] last_wd;
  always @(negedge clk) begin
    if (reg_wr) begin n_wr++; last_wa = reg_addr; last_wd = reg_wr_data; end
    if (reg_rd) n_rd++;
    if (frame_err) n_err++;
    if (mdio_oe) n_oe++;
    if (reg_wr && reg_rd) n_both++;
  end

  int n_chk, n_fail;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one master bit: output sampled just before the rising edge
  task automatic mbit(input logic b, input logic drv, output logic so, output logic sd);
    m_oe = drv; m_d = b;
    #60;
    so = mdio_oe; sd = mdio_o;
    mdc = 1'b1;
    #60;
    mdc = 1'b0;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta,
                            input logic [15:0] wd, input int stop_at,
                            output logic [18:0] oes, output logic [18:0] dat);
    logic so, sd;
    logic [13:0] hdr;
    logic [17:0] body;
    oes = '0; dat = '0;
    hdr = {st, op, pa, ra};
    body = {ta, wd};
    mbit(1'b0, 1'b1, so, sd);  // guard zero clears any leftover run of ones
    repeat (pre) mbit(1'b1, 1'b1, so, sd);
    for (int i = 13; i >= 0; i--) mbit(hdr[i], 1'b1, so, sd);
    if (op == 2'b10) begin
      for (int k = 1; k <= 19; k++) begin
        mbit(1'b1, 1'b0, so, sd);
        oes[19-k] = so; dat[19-k] = sd;
        if (k == stop_at) return;
      end
    end else begin
      for (int i = 17; i >= 0; i--) mbit(body[i], 1'b1, so, sd);
    end
    m_oe = 1'b0;
    #60;
  endtask

  logic [15:0] mdl [32];
  bit          mdl_vld [32];

  task automatic run_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta,
                           input logic [15:0] wd);
    int w0, r0, e0, o0;
    logic [18:0] oes, dat;
    bit started, err, acc, rd;
    logic [15:0] exp;
    w0 = n_wr; r0 = n_rd; e0 = n_err; o0 = n_oe;
    send_frame(pre, st, op, pa, ra, ta, wd, 0, oes, dat);
    rd      = (op == 2'b10);
    started = (pre >= PLEN);
    err     = started && (st != 2'b01 || op == 2'b00 || op == 2'b11 ||
                          (pa == PHY && !rd && ta != 2'b10));
    acc     = started && !err && pa == PHY;
    exp     = mdl_vld[ra] ? mdl[ra] : dflt(ra);
    check("wr_cnt", 32'(n_wr - w0), 32'(acc && !rd));
    check("rd_cnt", 32'(n_rd - r0), 32'(acc && rd));
    check("err_cnt", 32'(n_err - e0), 32'(err));
    if (acc && !rd) begin
      check("wr_addr", 32'(last_wa), 32'(ra));
      check("wr_data", 32'(last_wd), 32'(wd));
      mdl[ra] = wd; mdl_vld[ra] = 1'b1;
    end
    if (acc && rd) begin
      check("rd_oe", 32'(oes), 32'h1FFFF);
      check("rd_data", 32'(dat[16:0]), 32'({1'b0, exp}));
    end else begin
      check("oe_idle", 32'(n_oe - o0), 32'd0);
    end
    check("busy_end", 32'(busy), 32'd0);
    check("oe_end", 32'(mdio_oe), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [18:0] oes, dat;
    logic [1:0]  ta, op;
    logic [4:0]  pa;
    int          pre;
    #20;
    check("reset_outs", 32'({mdio_o, mdio_oe, reg_addr, reg_wr, reg_wr_data, reg_rd, busy, frame_err}), 32'd0);
    tb_init = 1'b0;
    arst_n = 1'b1;
    #20;

    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h0A, 2'b10, 16'hBEEF);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h03, 2'b10, 16'h1234);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h03, 2'b00, 16'h0000);
    run_frame(32, 2'b01, 2'b10, 5'd2, 5'h03, 2'b00, 16'h0000);
    run_frame(32, 2'b01, 2'b01, 5'd2, 5'h03, 2'b10, 16'hDEAD);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h0A, 2'b00, 16'h0000);
    run_frame(31, 2'b01, 2'b01, 5'd1, 5'h07, 2'b10, 16'h5555);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h07, 2'b10, 16'h5555);
    run_frame(32, 2'b01, 2'b11, 5'd1, 5'h09, 2'b10, 16'h7777);
    run_frame(32, 2'b00, 2'b01, 5'd1, 5'h09, 2'b10, 16'h7777);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h09, 2'b11, 16'h7777);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h09, 2'b10, 16'h1357);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h09, 2'b00, 16'h0000);

    // reset while the responder is driving data bit 7 of a read
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h05, 2'b10, 16'hA5C3);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'h05, 2'b00, 16'h0000, 11, oes, dat);
    check("pre_rst_oe", 32'(mdio_oe), 32'd1);
    check("pre_rst_bit7", 32'(mdio_o), 32'd1);
    arst_n = 1'b0;
    #1;
    check("rst_oe", 32'(mdio_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #9;
    m_oe = 1'b0;
    #20;
    arst_n = 1'b1;
    #20;
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h05, 2'b00, 16'h0000);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: pre = 31;
        1: pre = 33;
        default: pre = 32;
      endcase
      pa = ($urandom_range(0, 3) == 0) ? 5'd2 : 5'd1;
      op = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      ta = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      run_frame(pre, 2'b01, op, pa, 5'($urandom_range(0, 31)), ta, 16'($urandom));
    end

    check("wr_rd_excl", 32'(n_both), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/mdio_clause22_phy.md
Name: mdio_clause22_phy

Overview:
PHY-side (responder) end of the MDIO Clause 22 management interface. It decodes frames issued by the station-management master on mdc/mdio and answers read frames by driving the shared mdio line. It converts accepted frames into single-cycle read/write strobes on a local 32 x 16-bit register-file port. It sits inside PHY/loopback models and test fixtures, on the system clock, and oversamples the much slower MDC.

Parameters:
PHY_ADDR, 5'd1, PHY address this responder answers to; all other addresses are ignored.
PREAMBLE_LEN, 32, consecutive 1 bits required before ST; legal range 1..32.
SYNC_STAGES, 2, synchronizer flops on mdc and mdio_i; minimum 2.

Ports:
clk  input  1  system clock, 100 MHz, at least 8x MDC.
arst_n  input  1  asynchronous active-low reset.
mdc  input  1  management clock from the master; asynchronous to clk.
mdio_i  input  1  mdio pad input; asynchronous to clk.
mdio_o  output  1  value driven onto mdio when mdio_oe=1.
mdio_oe  output  1  pad drive enable. Top level: mdio = mdio_oe ? mdio_o : 1'bz, with an external pull-up.
reg_addr  output  5  register address of the current frame.
reg_wr  output  1  one-clk write strobe.
reg_wr_data  output  16  write data, valid while reg_wr=1.
reg_rd  output  1  one-clk read strobe.
reg_rd_data  input  16  read data; valid the clk after reg_rd.
busy  output  1  high from a valid ST through frame end.
frame_err  output  1  one-clk pulse on a protocol violation.

Behaviour:
- Reset values: all outputs 0. The FSM is in HUNT with the preamble count cleared. Reset is asynchronous: mdio_oe drops the moment arst_n falls, including mid-frame.
- mdc and mdio_i each pass through SYNC_STAGES flops.
- mdc_rise = synchronized mdc is 1 and its previous value was 0.
- All bit sampling and all mdio_o/mdio_oe updates happen only in the clk cycle where mdc_rise=1. The sampled value is the synchronized mdio, aligned to the same stage as mdc.
- States: HUNT, ST, OP, PHYAD, REGAD, TA, DATA.
- HUNT:
  - A sampled 1 increments a saturating counter (cap PREAMBLE_LEN).
  - A sampled 0 with counter == PREAMBLE_LEN is ST bit 1: go to ST and set busy=1.
  - A sampled 0 with counter < PREAMBLE_LEN clears the counter and stays in HUNT.
- ST: expects 1, then go to OP. A 0 pulses frame_err and returns to HUNT.
- OP: 2 bits. 01 = write, 10 = read. 00 or 11 pulses frame_err and returns to HUNT.
- PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR, return silently to HUNT with no strobes, mdio_oe=0 and no frame_err.
- REGAD: 5 bits, MSB first, loaded into reg_addr. Call the mdc_rise that samples the 5th bit R.
  - Read: reg_rd pulses in the cycle after R.
  - reg_rd_data is captured into the tx shift register one clk later.
- TA, read:
  - At R+1: no sample, mdio_oe stays 0 (both ends released).
  - At R+2: mdio_oe=1, mdio_o=0 (TA second bit).
- DATA, read:
  - At R+3 through R+18: mdio_o = data[15] down to data[0].
  - At R+19: mdio_oe=0, busy=0, go to HUNT.
- TA, write:
  - Sample at R+1 and expect 1; sample at R+2 and expect 0.
  - Either mismatch pulses frame_err and returns to HUNT with no strobe.
- DATA, write:
  - Samples at R+3 through R+18 shift into bits 15..0.
  - After the R+18 sample, pulse reg_wr for one clk with reg_wr_data and reg_addr valid. Set busy=0 and go to HUNT.
- After any frame end or error, the preamble count restarts from 0. Back-to-back frames each need a full preamble.
- Never sample mdio while mdio_oe=1.
- No timeout. If mdc stops, the state holds.
- reg_wr and reg_rd are never both high. Each fires at most once per frame.

Test Plan:
- Write frame, PHY_ADDR=1, REGAD 0x0A, data 0xBEEF, 32-bit preamble -> exactly one reg_wr with reg_addr=0x0A and reg_wr_data=0xBEEF; mdio_oe stays 0 throughout.
- Read frame, REGAD 0x03, reg_rd_data=0x1234 -> one reg_rd pulse. The master samples 0 on TA bit 2, then 0x1234 MSB first on the next 16 rising edges. mdio_oe=0 after the 16th bit; busy falls.
- Frame to PHYAD 2 (read and write) -> no strobes, mdio_oe=0, frame_err=0. An immediately following frame to PHYAD 1 is serviced.
- Preamble of 31 ones, then a valid frame body -> ignored. Same body with 32 ones -> accepted.
- OP=11, then ST=00, then write TA=11 -> one frame_err pulse each, no strobes. The next valid write still succeeds.
- arst_n asserted during read DATA bit 7 -> mdio_oe=0 immediately. After release, a new read frame returns correct data.
